// File: rtl/y_arith_pkg.sv
// ---------------------------------------------------------------------------
// y_arith_pkg
// Shared definitions for the yArith family of arithmetic engines.
//   state_e      : controller state encoding for the serial add/sub unit
//   OP_ADD/OP_SUB: operation select encoding (op input)
//   Y_WIDTH_DEF  : default operand/result width
// ---------------------------------------------------------------------------
package y_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int Y_WIDTH_DEF = 32;

endpackage : y_arith_pkg

// File: rtl/yAdder1.sv
// ---------------------------------------------------------------------------
// yAdder1
// One-bit full-adder cell shared by the yAdder/yArith datapath.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   z     : sum bit
//   cout  : carry out
// ---------------------------------------------------------------------------
module yAdder1 (
    output logic z,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign z       = a_xor_b ^ cin;
    assign cout    = (a & b) | (cin & a_xor_b);

endmodule : yAdder1

// File: rtl/y_serial_addsub.sv
// ---------------------------------------------------------------------------
// y_serial_addsub
// Bit-serial adder/subtractor: z = a + b (op=0) or z = a - b (op=1),
// one bit per clock, LSB first, through a single yAdder1 cell.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request, sampled only in IDLE (ignored otherwise, no queueing)
//   op    : 0 = add, 1 = subtract (latched with start)
//   a, b  : operands (latched with start; free to change afterwards)
//   busy  : high while bits are being processed
//   done  : one-cycle pulse, result valid
//   z     : result register
//   cout  : carry out of the MSB (subtract: 1 = no borrow)
//   ovf   : signed overflow
//   zero  : z == 0
// Timing: start accepted at edge E0, bits processed at E1..E(WIDTH),
// done high for the cycle after E(WIDTH), back in IDLE one cycle later.
// ---------------------------------------------------------------------------
module y_serial_addsub
    import y_arith_pkg::*;
#(
    parameter int WIDTH = Y_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Registered state
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               op_q, op_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    // Single full-adder cell; subtraction inverts b and seeds carry with 1
    logic               add_b;
    logic               add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   z_shift;

    assign add_b   = b_sh_q[0] ^ op_q;
    assign z_shift = {add_sum, z_q[WIDTH-1:1]};

    yAdder1 u_add (
        .z    (add_sum),
        .cout (add_cout),
        .a    (a_sh_q[0]),
        .b    (add_b),
        .cin  (carry_q)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        op_d    = op_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = op;
                    // Two's-complement subtract: +1 enters as the LSB carry
                    carry_d = (op == OP_SUB);
                    cnt_d   = '0;
                end
            end

            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = add_cout;
                cnt_d   = cnt_q + 1'b1;
                z_d     = z_shift;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cout_d  = add_cout;
                    // On the last bit a_sh_q[0]/b_sh_q[0] still hold the
                    // original operand MSBs, so no separate sign copies.
                    ovf_d   = (a_sh_q[0] ^ b_sh_q[0] ^ op_q ^ 1'b1)
                              & (add_sum ^ a_sh_q[0]);
                    zero_d  = (z_shift == '0);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // Handshake outputs decode the state register directly
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign z    = z_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule : y_serial_addsub

// File: tb/tb_y_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_y_serial_addsub
// Directed bench for y_serial_addsub at WIDTH=8.
// ---------------------------------------------------------------------------
module tb_y_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] z;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    y_serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start one operation and return when done is observed.
    // Edge 1 is the accepting edge; done_edge is the edge after which done=1.
    task automatic run_op(input logic op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          output int done_edge, output int busy_cycles);
        int k;
        @(posedge clk); #1;
        start = 1'b1; op = op_v; a = a_v; b = b_v;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        op = ~op_v;
        k = 1;
        busy_cycles = busy ? 1 : 0;
        done_edge = 0;
        while (done_edge == 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (busy) busy_cycles++;
            if (done) done_edge = k;
        end
        if (done_edge == 0) chk("timeout_done", 0, 1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || done) && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy || done) chk("timeout_idle", 0, 1);
    endtask

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] z;
        logic         c;
        logic         v;
        logic         zr;
    } vec_t;

    vec_t vecs[6] = '{
        '{1'b1, 8'd5,   8'd3,   8'h02, 1'b1, 1'b0, 1'b0},
        '{1'b1, 8'd3,   8'd5,   8'hFE, 1'b0, 1'b0, 1'b0},
        '{1'b1, 8'h80,  8'h01,  8'h7F, 1'b1, 1'b1, 1'b0},
        '{1'b1, 8'h07,  8'h07,  8'h00, 1'b1, 1'b0, 1'b1},
        '{1'b0, 8'h7F,  8'h01,  8'h80, 1'b0, 1'b1, 1'b0},
        '{1'b0, 8'hFF,  8'h01,  8'h00, 1'b1, 1'b0, 1'b1}
    };

    initial begin
        int de, bc, ndone, d1, d2;
        logic [W:0]   s9;
        logic [W-1:0] ez;
        logic         ev;

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_z",    z,    0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf",  ovf,  0);
        chk("rst_zero", zero, 1);
        #4 rst = 1'b0;

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, de, bc);
            chk($sformatf("v%0d_done_edge", i), de, 9);
            chk($sformatf("v%0d_busy_cyc", i), bc, 8);
            chk($sformatf("v%0d_z", i),    z,    vecs[i].z);
            chk($sformatf("v%0d_cout", i), cout, vecs[i].c);
            chk($sformatf("v%0d_ovf", i),  ovf,  vecs[i].v);
            chk($sformatf("v%0d_zero", i), zero, vecs[i].zr);
            @(posedge clk); #1;
            chk($sformatf("v%0d_hold_z", i), z, vecs[i].z);
            chk($sformatf("v%0d_idle", i), {busy, done}, 2'b00);
        end

        // start re-pulsed during RUN must be ignored
        @(posedge clk); #1;
        start = 1'b1; op = 1'b1; a = 8'd5; b = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; d1 = 0;
        for (int k = 2; k <= 20; k++) begin
            if (k == 4) begin
                start = 1'b1; op = 1'b0; a = 8'hAA; b = 8'h11;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (d1 == 0) begin
                    d1 = k;
                    chk("repulse_z", z, 8'h02);
                    chk("repulse_cout", cout, 1);
                end
            end
        end
        chk("repulse_ndone", ndone, 1);
        chk("repulse_edge", d1, 9);
        wait_idle();

        // start held high: one result per WIDTH+2 cycles
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; a = 8'd1; b = 8'd2;
        d1 = 0; d2 = 0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (d1 == 0) begin
                    d1 = k;
                    chk("held_z", z, 8'h03);
                end else if (d2 == 0) begin
                    d2 = k;
                end
            end
        end
        start = 1'b0;
        chk("held_period", d2 - d1, 10);
        wait_idle();

        // async reset mid-RUN
        run_op(1'b0, 8'h7F, 8'h01, de, bc);   // leaves z=80, ovf=1
        @(posedge clk); #1;
        start = 1'b1; op = 1'b1; a = 8'h80; b = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_z",    z,    0);
        chk("arst_cout", cout, 0);
        chk("arst_ovf",  ovf,  0);
        chk("arst_zero", zero, 1);
        #3 rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        run_op(1'b1, 8'd5, 8'd3, de, bc);
        chk("post_arst_edge", de, 9);
        chk("post_arst_z", z, 8'h02);
        chk("post_arst_cout", cout, 1);

        // strided sweep over a, b and op
        for (int ai = 0; ai < 256; ai += 17) begin
            for (int bi = 0; bi < 256; bi += 17) begin
                for (int oi = 0; oi < 2; oi++) begin
                    if (oi == 1) s9 = {1'b0, W'(ai)} - {1'b0, W'(bi)} + 9'h100;
                    else         s9 = {1'b0, W'(ai)} + {1'b0, W'(bi)};
                    ez = s9[W-1:0];
                    if (oi == 1)
                        ev = ($signed(W'(ai)) - $signed(W'(bi)) > 127) ||
                             ($signed(W'(ai)) - $signed(W'(bi)) < -128);
                    else
                        ev = ($signed(W'(ai)) + $signed(W'(bi)) > 127) ||
                             ($signed(W'(ai)) + $signed(W'(bi)) < -128);
                    run_op(oi[0], W'(ai), W'(bi), de, bc);
                    chk($sformatf("sw_z_%0d_%0d_%0d", ai, bi, oi), z, ez);
                    chk($sformatf("sw_c_%0d_%0d_%0d", ai, bi, oi), cout, s9[W]);
                    chk($sformatf("sw_v_%0d_%0d_%0d", ai, bi, oi), ovf, ev);
                    chk($sformatf("sw_zr_%0d_%0d_%0d", ai, bi, oi), zero, ez == 0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_y_serial_addsub
